// File: rtl/mastermind_scorer_pkg.sv
// rtl/mastermind_scorer_pkg.sv - default sizes and FSM state encoding for the scorer
package mastermind_scorer_pkg;

  localparam int N_PEGS_DEF  = 4;
  localparam int COLOR_W_DEF = 2;
  localparam int CNT_W_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXACT = 2'd1,
    ST_MATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mastermind_scorer_color_hist.sv
// rtl/mastermind_scorer_color_hist.sv - per-colour occurrence counters with clear, increment and read
module color_hist #(
  parameter int COLOR_W = 2,
  parameter int CNT_W   = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [COLOR_W-1:0] inc_color_i,
  input  logic [COLOR_W-1:0] rd_color_i,
  output logic [CNT_W-1:0]   rd_cnt_o
);

  localparam int N_COLORS = 1 << COLOR_W;

  logic [CNT_W-1:0] cnt_q [N_COLORS];
  logic [CNT_W-1:0] cnt_d [N_COLORS];

  // Clear wins over increment so a fresh score never inherits old counts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      for (int i = 0; i < N_COLORS; i++) begin
        cnt_d[i] = '0;
      end
    end else if (inc_i) begin
      cnt_d[inc_color_i] = cnt_q[inc_color_i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_COLORS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_cnt_o = cnt_q[rd_color_i];

endmodule

// File: rtl/mastermind_scorer.sv
// rtl/mastermind_scorer.sv - sequential black/white peg scorer with start/done handshake
module mastermind_scorer
  import mastermind_scorer_pkg::*;
#(
  parameter int N_PEGS  = N_PEGS_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_PEGS*COLOR_W-1:0] code,
  input  logic [N_PEGS*COLOR_W-1:0] guess,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          black,
  output logic [CNT_W-1:0]          white
);

  localparam int IDX_W = (N_PEGS > 1) ? $clog2(N_PEGS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PEGS - 1);
  localparam logic [COLOR_W-1:0] LAST_COL = {COLOR_W{1'b1}};

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [COLOR_W-1:0]        col_q, col_d;
  logic [CNT_W-1:0]          acc_b_q, acc_b_d;
  logic [CNT_W-1:0]          acc_w_q, acc_w_d;
  logic [CNT_W-1:0]          black_q, black_d;
  logic [CNT_W-1:0]          white_q, white_d;
  logic [N_PEGS*COLOR_W-1:0] code_q, code_d;
  logic [N_PEGS*COLOR_W-1:0] guess_q, guess_d;

  logic               hist_clr;
  logic               hist_inc;
  logic [COLOR_W-1:0] code_peg;
  logic [COLOR_W-1:0] guess_peg;
  logic [CNT_W-1:0]   hc_cnt;
  logic [CNT_W-1:0]   hg_cnt;
  logic [CNT_W-1:0]   min_cnt;

  assign code_peg  = code_q[idx_q*COLOR_W +: COLOR_W];
  assign guess_peg = guess_q[idx_q*COLOR_W +: COLOR_W];
  assign min_cnt   = (hc_cnt < hg_cnt) ? hc_cnt : hg_cnt;

  // Only unmatched pegs are histogrammed, so white never double-counts blacks.
  color_hist #(.COLOR_W(COLOR_W), .CNT_W(CNT_W)) hist_c (
    .clk_i       (CLK),
    .rst_ni      (reset),
    .clr_i       (hist_clr),
    .inc_i       (hist_inc),
    .inc_color_i (code_peg),
    .rd_color_i  (col_q),
    .rd_cnt_o    (hc_cnt)
  );

  color_hist #(.COLOR_W(COLOR_W), .CNT_W(CNT_W)) hist_g (
    .clk_i       (CLK),
    .rst_ni      (reset),
    .clr_i       (hist_clr),
    .inc_i       (hist_inc),
    .inc_color_i (guess_peg),
    .rd_color_i  (col_q),
    .rd_cnt_o    (hg_cnt)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    col_d    = col_q;
    acc_b_d  = acc_b_q;
    acc_w_d  = acc_w_q;
    black_d  = black_q;
    white_d  = white_q;
    code_d   = code_q;
    guess_d  = guess_q;
    hist_clr = 1'b0;
    hist_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          code_d   = code;
          guess_d  = guess;
          hist_clr = 1'b1;
          acc_b_d  = '0;
          acc_w_d  = '0;
          idx_d    = '0;
          col_d    = '0;
          state_d  = ST_EXACT;
        end
      end
      ST_EXACT: begin
        if (code_peg == guess_peg) begin
          acc_b_d = acc_b_q + CNT_W'(1);
        end else begin
          hist_inc = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_MATCH;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_MATCH: begin
        acc_w_d = acc_w_q + min_cnt;
        if (col_q == LAST_COL) begin
          black_d = acc_b_q;
          white_d = acc_w_d;
          state_d = ST_DONE;
        end else begin
          col_d = col_q + COLOR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      acc_b_q <= '0;
      acc_w_q <= '0;
      black_q <= '0;
      white_q <= '0;
      code_q  <= '0;
      guess_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      acc_b_q <= acc_b_d;
      acc_w_q <= acc_w_d;
      black_q <= black_d;
      white_q <= white_d;
      code_q  <= code_d;
      guess_q <= guess_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign black = black_q;
  assign white = white_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// tb/tb_mastermind_scorer.sv - directed self-checking bench for mastermind_scorer
module tb_mastermind_scorer;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] code = '0;
  logic [7:0] guess = '0;
  logic       busy;
  logic       done;
  logic [2:0] black;
  logic [2:0] white;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mastermind_scorer dut (
    .CLK   (CLK),
    .reset (reset),
    .start (start),
    .code  (code),
    .guess (guess),
    .busy  (busy),
    .done  (done),
    .black (black),
    .white (white)
  );

  typedef struct {
    logic [7:0] code;
    logic [7:0] guess;
    int         b;
    int         w;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pegs listed p3..p0, so {p3,p2,p1,p0} packs with p0 in the low bits.
  function automatic logic [7:0] pegs(input int p3, input int p2, input int p1, input int p0);
    return {2'(p3), 2'(p2), 2'(p1), 2'(p0)};
  endfunction

  task automatic score(input logic [7:0] c, input logic [7:0] g, input int eb, input int ew,
                       input int pb, input int pw, input bit hold_chk, input bit scramble,
                       input string tag);
    int lat;
    bit seen;
    bit held;
    @(posedge CLK); #1;
    code  = c;
    guess = g;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
    lat  = 0;
    seen = 1'b0;
    held = 1'b1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      if (scramble && i == 3) begin
        code  = 8'($urandom);
        guess = 8'($urandom);
      end
      @(posedge CLK); #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else if (hold_chk && (int'(black) != pb || int'(white) != pw)) begin
        held = 1'b0;
      end
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_black"}, int'(black), eb);
    check({tag, "_white"}, int'(white), ew);
    if (hold_chk) check({tag, "_held"}, int'(held), 1);
  endtask

  initial begin
    int dones;
    int idle_seen;

    vecs[0] = '{pegs(3,2,1,0), pegs(3,2,1,0), 4, 0};
    vecs[1] = '{pegs(3,2,1,0), pegs(2,3,0,1), 0, 4};
    vecs[2] = '{pegs(1,1,0,0), pegs(2,0,1,0), 1, 2};
    vecs[3] = '{pegs(0,0,0,0), pegs(3,3,3,3), 0, 0};
    vecs[4] = '{pegs(2,2,3,3), pegs(3,3,2,2), 0, 4};
    vecs[5] = '{pegs(1,2,3,0), pegs(1,1,1,1), 1, 0};
    vecs[6] = '{pegs(0,0,1,1), pegs(0,1,0,2), 1, 2};

    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_black", int'(black), 0);
    check("rst_white", int'(white), 0);
    @(negedge CLK);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      score(vecs[v].code, vecs[v].guess, vecs[v].b, vecs[v].w, 0, 0, 1'b0, 1'b0,
            $sformatf("vec%0d", v));
    end

    // start held high: one done per IDLE visit
    @(posedge CLK); #1;
    code  = pegs(0,0,0,0);
    guess = pegs(3,3,3,3);
    start = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (done) dones++;
    end
    start = 1'b0;
    check("hold_dones", dones, 1);
    idle_seen = 0;
    for (int i = 0; i < 30 && idle_seen == 0; i++) begin
      @(posedge CLK); #1;
      if (!busy) idle_seen = 1;
    end
    check("hold_drain", idle_seen, 1);
    check("hold_black", int'(black), 0);
    check("hold_white", int'(white), 0);

    // reset mid-scoring
    score(vecs[0].code, vecs[0].guess, 4, 0, 0, 0, 1'b0, 1'b0, "pre_rst");
    @(posedge CLK); #1;
    code  = vecs[2].code;
    guess = vecs[2].guess;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_black", int'(black), 0);
    check("abort_white", int'(white), 0);
    @(negedge CLK);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (done || busy) dones++;
    end
    check("abort_quiet", dones, 0);
    score(vecs[2].code, vecs[2].guess, 1, 2, 0, 0, 1'b0, 1'b0, "post_rst");

    // back-to-back, with inputs changed mid-scoring on the second run
    score(vecs[0].code, vecs[0].guess, 4, 0, 0, 0, 1'b0, 1'b0, "b2b_first");
    score(vecs[1].code, vecs[1].guess, 0, 4, 4, 0, 1'b1, 1'b1, "b2b_second");
    score(vecs[2].code, vecs[2].guess, 1, 2, 0, 4, 1'b1, 1'b1, "b2b_third");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
